// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared enums, opcode constants and control bundle for ctrl_decode_stage
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLT    = 4'b0101,
        ALU_SLTU   = 4'b0110,
        ALU_SLL    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASS_B = 4'b1010,
        ALU_ADD_PC = 4'b1011
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        jalr;
        alu_ctrl_e   alu_ctrl;
        imm_src_e    imm_src;
        result_src_e result_src;
        logic [2:0]  br_funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } ctrl_bundle_t;

    // All flags off, ADD, register indices taken straight from the instruction fields.
    function automatic ctrl_bundle_t nop_bundle(input logic [31:0] instr);
        ctrl_bundle_t b;
        b            = '0;
        b.alu_ctrl   = ALU_ADD;
        b.imm_src    = IMM_I;
        b.result_src = RES_ALU;
        b.rd         = instr[11:7];
        b.rs1        = instr[19:15];
        b.rs2        = instr[24:20];
        return b;
    endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// rtl/ctrl_decode_stage_if.sv - fetch-side and execute-side handshake bundle of ctrl_decode_stage
interface ctrl_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic [3:0]      alu_ctrl;
    logic [2:0]      imm_src;
    logic [1:0]      result_src;
    logic [2:0]      br_funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc_out;
    logic            illegal;

    // Decode stage view.
    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, reg_write, mem_write, alu_src, branch, jump, jalr,
               alu_ctrl, imm_src, result_src, br_funct3, rd, rs1, rs2, pc_out, illegal
    );

    // Surrounding pipeline view (fetch driver plus execute consumer).
    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, reg_write, mem_write, alu_src, branch, jump, jalr,
               alu_ctrl, imm_src, result_src, br_funct3, rd, rs1, rs2, pc_out, illegal
    );
endinterface

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational RV32I decode into ctrl_bundle_t (CTRL_ILLEGAL_EN flags bad encodings)
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output logic         rs1_used,
    output logic         rs2_used
);

    // instr[5] separates OP (register) from OP-IMM; only OP may select SUB.
    function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic bit30, input logic is_reg);
        alu_ctrl_e op;
        case (f3)
            3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

`ifdef CTRL_ILLEGAL_EN
    // True only for opcode/funct3/funct7 combinations that RV32I defines among the decoded opcodes.
    function automatic logic enc_legal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            OPC_OP:     ok = (f7 == 7'b0000000) ||
                             ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            OPC_OP_IMM: begin
                if (f3 == 3'b001)
                    ok = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    ok = 1'b1;
            end
            OPC_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OPC_STORE:  ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            OPC_JALR:   ok = (f3 == 3'b000);
            OPC_JAL,
            OPC_LUI,
            OPC_AUIPC:  ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction
`else
    logic unused_funct7;
    assign unused_funct7 = ^{instr[31], instr[29:25]};
`endif

    // Start from a NOP bundle and set only what each opcode needs.
    always_comb begin
        bundle   = nop_bundle(instr);
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                bundle.reg_write = 1'b1;
                bundle.alu_ctrl  = alu_op(instr[14:12], instr[30], instr[5]);
                rs1_used         = 1'b1;
                rs2_used         = 1'b1;
            end
            OPC_OP_IMM: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_ctrl  = alu_op(instr[14:12], instr[30], instr[5]);
                rs1_used         = 1'b1;
            end
            OPC_LOAD: begin
                bundle.reg_write  = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.result_src = RES_MEM;
                rs1_used          = 1'b1;
            end
            OPC_STORE: begin
                bundle.mem_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.imm_src   = IMM_S;
                rs1_used         = 1'b1;
                rs2_used         = 1'b1;
            end
            OPC_BRANCH: begin
                bundle.branch    = 1'b1;
                bundle.alu_ctrl  = ALU_SUB;
                bundle.imm_src   = IMM_B;
                bundle.br_funct3 = instr[14:12];
                rs1_used         = 1'b1;
                rs2_used         = 1'b1;
            end
            OPC_JAL: begin
                bundle.reg_write  = 1'b1;
                bundle.jump       = 1'b1;
                bundle.imm_src    = IMM_J;
                bundle.result_src = RES_PC4;
            end
            OPC_JALR: begin
                bundle.reg_write  = 1'b1;
                bundle.jump       = 1'b1;
                bundle.jalr       = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.imm_src    = IMM_I;
                bundle.result_src = RES_PC4;
                rs1_used          = 1'b1;
            end
            OPC_LUI: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_ctrl  = ALU_PASS_B;
                bundle.imm_src   = IMM_U;
            end
            OPC_AUIPC: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_ctrl  = ALU_ADD_PC;
                bundle.imm_src   = IMM_U;
            end
            default: begin
            end
        endcase
`ifdef CTRL_ILLEGAL_EN
        // A bad encoding still flows as an inert bundle so execute can raise the trap.
        if (!enc_legal(instr)) begin
            bundle         = nop_bundle(instr);
            bundle.illegal = 1'b1;
            rs1_used       = 1'b0;
            rs2_used       = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered RV32I control decode stage with handshake, flush and load-use interlock (CTRL_ILLEGAL_EN)
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic clk,
    input  logic rst,
    ctrl_decode_stage_if.slave bus
);

    ctrl_bundle_t    dec;
    logic            dec_rs1_used;
    logic            dec_rs2_used;
    ctrl_bundle_t    q;
    logic [XLEN-1:0] pc_q;
    logic            out_valid_q;
    logic            hazard;
    logic            accept;

    ctrl_decoder u_decoder (
        .instr    (bus.instr),
        .bundle   (dec),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // A load sitting in the output register whose rd is read by the incoming instruction.
    always_comb begin
        hazard = out_valid_q && (q.result_src == RES_MEM) && (q.rd != 5'd0) && bus.in_valid &&
                 ((dec_rs1_used && (dec.rs1 == q.rd)) || (dec_rs2_used && (dec.rs2 == q.rd)));
    end

    assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready) &&
                          !((LOAD_USE_STALL != 0) && hazard);
    assign accept       = bus.in_ready && bus.in_valid;

    // Output register: flush beats accept beats drain; a held bundle stays put otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            q           <= '0;
            pc_q        <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            q           <= dec;
            pc_q        <= bus.pc;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.reg_write  = q.reg_write;
    assign bus.mem_write  = q.mem_write;
    assign bus.alu_src    = q.alu_src;
    assign bus.branch     = q.branch;
    assign bus.jump       = q.jump;
    assign bus.jalr       = q.jalr;
    assign bus.alu_ctrl   = q.alu_ctrl;
    assign bus.imm_src    = q.imm_src;
    assign bus.result_src = q.result_src;
    assign bus.br_funct3  = q.br_funct3;
    assign bus.rd         = q.rd;
    assign bus.rs1        = q.rs1;
    assign bus.rs2        = q.rs2;
    assign bus.pc_out     = pc_q;
    assign bus.illegal    = q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - scoreboard bench for ctrl_decode_stage
module tb_ctrl_decode_stage;
    import ctrl_pkg::*;

    typedef struct packed {
        ctrl_bundle_t b;
        logic [31:0]  pc;
    } exp_t;

    localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB4  = 32'h40118233; // sub  x4,x3,x1
    localparam logic [31:0] I_BLT   = 32'hFE20CCE3; // blt  x1,x2,-8
    localparam logic [31:0] I_SW    = 32'h0020A223; // sw   x2,4(x1)
    localparam logic [31:0] I_JAL   = 32'h008000EF; // jal  x1,8
    localparam logic [31:0] I_JALR  = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] I_SRAI  = 32'h4030D413; // srai x8,x1,3
    localparam logic [31:0] I_AUIPC = 32'h00001497; // auipc x9,1
    localparam logic [31:0] I_SLTU  = 32'h0020B533; // sltu x10,x1,x2
    localparam logic [31:0] I_BAD   = 32'h0000007F; // unknown opcode
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_LUI7  = 32'h000283B7; // lui  x7,0x28 (rs1 field = 5)

`ifdef CTRL_ILLEGAL_EN
    localparam logic BAD_ILL = 1'b1;
`else
    localparam logic BAD_ILL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_decode_stage_if #(.XLEN(32)) ifc0 ();
    ctrl_decode_stage_if #(.XLEN(32)) ifc1 ();

    ctrl_decode_stage #(.XLEN(32), .LOAD_USE_STALL(1)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    ctrl_decode_stage #(.XLEN(32), .LOAD_USE_STALL(0)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    assign ifc1.in_valid  = ifc0.in_valid;
    assign ifc1.instr     = ifc0.instr;
    assign ifc1.pc        = ifc0.pc;
    assign ifc1.flush     = ifc0.flush;
    assign ifc1.out_ready = ifc0.out_ready;

    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    ctrl_bundle_t exp_cur;
    exp_t         mon_e;

    function automatic ctrl_bundle_t mk(input logic rw, input logic mw, input logic as, input logic br,
                                        input logic j, input logic jr, input logic [3:0] alu,
                                        input logic [2:0] imm, input logic [1:0] res, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic ill);
        ctrl_bundle_t b;
        b.reg_write  = rw;
        b.mem_write  = mw;
        b.alu_src    = as;
        b.branch     = br;
        b.jump       = j;
        b.jalr       = jr;
        b.alu_ctrl   = alu_ctrl_e'(alu);
        b.imm_src    = imm_src_e'(imm);
        b.result_src = result_src_e'(res);
        b.br_funct3  = f3;
        b.rd         = rd;
        b.rs1        = rs1;
        b.rs2        = rs2;
        b.illegal    = ill;
        return b;
    endfunction

    function automatic ctrl_bundle_t got_b();
        ctrl_bundle_t b;
        b.reg_write  = ifc0.reg_write;
        b.mem_write  = ifc0.mem_write;
        b.alu_src    = ifc0.alu_src;
        b.branch     = ifc0.branch;
        b.jump       = ifc0.jump;
        b.jalr       = ifc0.jalr;
        b.alu_ctrl   = alu_ctrl_e'(ifc0.alu_ctrl);
        b.imm_src    = imm_src_e'(ifc0.imm_src);
        b.result_src = result_src_e'(ifc0.result_src);
        b.br_funct3  = ifc0.br_funct3;
        b.rd         = ifc0.rd;
        b.rs1        = ifc0.rs1;
        b.rs2        = ifc0.rs2;
        b.illegal    = ifc0.illegal;
        return b;
    endfunction

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    //                  rw mw as br j  jr alu      imm     res    f3      rd     rs1    rs2    ill
    ctrl_bundle_t e_add3, e_sub4, e_blt, e_sw, e_jal, e_jalr, e_srai, e_auipc, e_sltu, e_bad;
    ctrl_bundle_t e_lw5, e_add6, e_lui7;
    logic [31:0]  vi [10];
    ctrl_bundle_t ve [10];

    initial begin
        e_add3  = mk(1, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 3'b000, 5'd3,  5'd1, 5'd2, 0);
        e_sub4  = mk(1, 0, 0, 0, 0, 0, 4'b0001, 3'b000, 2'b00, 3'b000, 5'd4,  5'd3, 5'd1, 0);
        e_blt   = mk(0, 0, 0, 1, 0, 0, 4'b0001, 3'b010, 2'b00, 3'b100, 5'd25, 5'd1, 5'd2, 0);
        e_sw    = mk(0, 1, 1, 0, 0, 0, 4'b0000, 3'b001, 2'b00, 3'b000, 5'd4,  5'd1, 5'd2, 0);
        e_jal   = mk(1, 0, 0, 0, 1, 0, 4'b0000, 3'b011, 2'b10, 3'b000, 5'd1,  5'd0, 5'd8, 0);
        e_jalr  = mk(1, 0, 1, 0, 1, 1, 4'b0000, 3'b000, 2'b10, 3'b000, 5'd0,  5'd1, 5'd0, 0);
        e_srai  = mk(1, 0, 1, 0, 0, 0, 4'b1001, 3'b000, 2'b00, 3'b000, 5'd8,  5'd1, 5'd3, 0);
        e_auipc = mk(1, 0, 1, 0, 0, 0, 4'b1011, 3'b100, 2'b00, 3'b000, 5'd9,  5'd0, 5'd0, 0);
        e_sltu  = mk(1, 0, 0, 0, 0, 0, 4'b0110, 3'b000, 2'b00, 3'b000, 5'd10, 5'd1, 5'd2, 0);
        e_bad   = mk(0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 3'b000, 5'd0,  5'd0, 5'd0, BAD_ILL);
        e_lw5   = mk(1, 0, 1, 0, 0, 0, 4'b0000, 3'b000, 2'b01, 3'b000, 5'd5,  5'd1, 5'd0, 0);
        e_add6  = mk(1, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 3'b000, 5'd6,  5'd5, 5'd2, 0);
        e_lui7  = mk(1, 0, 1, 0, 0, 0, 4'b1010, 3'b100, 2'b00, 3'b000, 5'd7,  5'd5, 5'd0, 0);
        vi = '{I_ADD3, I_SUB4, I_BLT, I_SW, I_JAL, I_JALR, I_SRAI, I_AUIPC, I_SLTU, I_BAD};
        ve = '{e_add3, e_sub4, e_blt, e_sw, e_jal, e_jalr, e_srai, e_auipc, e_sltu, e_bad};
    end

    // Expected response is queued at the moment the stage accepts an instruction.
    always @(negedge clk) begin
        if (!rst && ifc0.in_valid && ifc0.in_ready)
            exp_q.push_back('{b: exp_cur, pc: ifc0.pc});
    end

    // Monitor: every bundle transferred to execute must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && ifc0.out_valid && ifc0.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got rd=%0d pc=%h expected no bundle", ifc0.rd, ifc0.pc_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bundle", {got_b(), ifc0.pc_out}, mon_e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [31:0] p, input ctrl_bundle_t e, output int waits);
        ifc0.in_valid = 1'b1;
        ifc0.instr    = i;
        ifc0.pc       = p;
        exp_cur       = e;
        waits         = 0;
        @(negedge clk);
        while (!ifc0.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!ifc0.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waits);
        end
        @(posedge clk);
        #1;
        ifc0.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int total;
        rst            = 1'b1;
        ifc0.in_valid  = 1'b0;
        ifc0.instr     = '0;
        ifc0.pc        = '0;
        ifc0.flush     = 1'b0;
        ifc0.out_ready = 1'b1;
        exp_cur        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_outputs", {got_b(), ifc0.pc_out, ifc0.out_valid}, '0);
        chk("reset_in_ready", ifc0.in_ready, 1);

        // Back-to-back stream with no hazards: one accept per cycle.
        @(posedge clk);
        #1;
        total = 0;
        for (int i = 0; i < 10; i++) begin
            send(vi[i], 32'h100 + 32'(i * 4), ve[i], w);
            total += w;
        end
        chk("stream_waits", total, 0);
        idle(3);
        chk("stream_drained", exp_q.size(), 0);

        // Load-use: one stall cycle, a bubble, then the dependent add.
        send(I_LW5, 32'h200, e_lw5, w);
        ifc0.instr    = I_ADD6;
        ifc0.pc       = 32'h204;
        exp_cur       = e_add6;
        ifc0.in_valid = 1'b1;
        @(negedge clk);
        chk("hazard_in_ready", ifc0.in_ready, 0);
        chk("nostall_in_ready", ifc1.in_ready, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bubble_out_valid", ifc0.out_valid, 0);
        chk("bubble_in_ready", ifc0.in_ready, 1);
        chk("nostall_no_bubble", {ifc1.out_valid, ifc1.rd}, {1'b1, 5'd6});
        @(posedge clk);
        #1 ifc0.in_valid = 1'b0;

        // LUI does not read rs1, so no stall behind the load.
        send(I_LW5, 32'h210, e_lw5, w);
        send(I_LUI7, 32'h214, e_lui7, w);
        chk("lui_no_stall_waits", w, 0);
        idle(3);
        chk("load_drained", exp_q.size(), 0);

        // Back-pressure for 3 cycles, then release accepts the waiting instruction.
        ifc0.out_ready = 1'b0;
        send(I_ADD3, 32'h300, e_add3, w);
        ifc0.instr    = I_SUB4;
        ifc0.pc       = 32'h304;
        exp_cur       = e_sub4;
        ifc0.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_in_ready", ifc0.in_ready, 0);
            chk("hold_bundle", {got_b(), ifc0.pc_out, ifc0.out_valid}, {e_add3, 32'h300, 1'b1});
            @(posedge clk);
            #1;
        end
        ifc0.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", ifc0.in_ready, 1);
        @(posedge clk);
        #1 ifc0.in_valid = 1'b0;
        idle(3);
        chk("hold_drained", exp_q.size(), 0);

        // Flush with in_valid: not accepted, then accepted once flush drops.
        ifc0.instr    = I_ADD6;
        ifc0.pc       = 32'h400;
        exp_cur       = e_add6;
        ifc0.in_valid = 1'b1;
        ifc0.flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", ifc0.in_ready, 0);
        @(posedge clk);
        #1 ifc0.flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", ifc0.out_valid, 0);
        chk("post_flush_in_ready", ifc0.in_ready, 1);
        @(posedge clk);
        #1 ifc0.in_valid = 1'b0;
        idle(3);
        chk("flush_drained", exp_q.size(), 0);

        // Flush kills a bundle that is being held.
        ifc0.out_ready = 1'b0;
        send(I_ADD3, 32'h500, e_add3, w);
        ifc0.flush = 1'b1;
        @(posedge clk);
        #1 ifc0.flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_hold_out_valid", ifc0.out_valid, 0);
        @(posedge clk);
        #1 ifc0.out_ready = 1'b1;

        // Flush together with a hazard: flush wins and the hazard is gone afterwards.
        send(I_LW5, 32'h600, e_lw5, w);
        ifc0.instr    = I_ADD6;
        ifc0.pc       = 32'h604;
        exp_cur       = e_add6;
        ifc0.in_valid = 1'b1;
        ifc0.flush    = 1'b1;
        @(negedge clk);
        chk("flush_hazard_in_ready", ifc0.in_ready, 0);
        @(posedge clk);
        #1 ifc0.flush = 1'b0;
        @(negedge clk);
        chk("flush_hazard_out_valid", ifc0.out_valid, 0);
        chk("flush_hazard_cleared", ifc0.in_ready, 1);
        @(posedge clk);
        #1 ifc0.in_valid = 1'b0;
        idle(3);
        chk("flush_hazard_drained", exp_q.size(), 0);

        // Reset in the middle of a stall clears everything.
        ifc0.out_ready = 1'b0;
        send(I_ADD3, 32'h700, e_add3, w);
        ifc0.instr    = I_SUB4;
        ifc0.pc       = 32'h704;
        exp_cur       = e_sub4;
        ifc0.in_valid = 1'b1;
        @(negedge clk);
        chk("stall_before_rst", ifc0.in_ready, 0);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        ifc0.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_outputs", {got_b(), ifc0.pc_out, ifc0.out_valid}, '0);
        ifc0.out_ready = 1'b1;

        idle(3);
        chk("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
